// File: rtl/bt_air_pkg.sv
// bt_air_pkg
// Shared definitions for the bt_air_channel air-interface model:
//   - RF channel limit (channels above FK_MAX carry no transmission)
//   - 16-bit Galois LFSR polynomial, step and seed-fix helpers
//   - tx_rec_t: one device's {enable, bit, channel} as seen on the air
package bt_air_pkg;

    localparam int unsigned FK_MAX    = 78;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    // Channel field width inside the TX record; device channels are zero-extended into it.
    localparam int unsigned TX_FK_W   = 16;

    typedef struct packed {
        logic               en;
        logic               dat;
        logic [TX_FK_W-1:0] fk;
    } tx_rec_t;

    // A channel index above FK_MAX is treated as "not transmitting".
    function automatic logic fk_in_range(input logic [TX_FK_W-1:0] fk);
        return (fk <= TX_FK_W'(FK_MAX));
    endfunction

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] nxt;
        nxt = {1'b0, s[LFSR_W-1:1]};
        if (s[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // The all-zero state is a lock-up state for the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/bt_air_lfsr.sv
// bt_air_lfsr
// One 16-bit Galois LFSR used as a per-receiver noise / bit-error source.
// Ports:
//   clk_i      clock
//   rstz_i     synchronous active-low reset, loads the (fixed-up) seed
//   advance_i  step the LFSR by one position
//   load_i     reload the seed; takes priority over advance_i
//   seed_i     seed value (all-zero is replaced by 16'h0001)
//   state_o    current LFSR state
module bt_air_lfsr
    import bt_air_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstz_i,
    input  logic              advance_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next state: a seed load wins over a coincident advance.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_fix(seed_i);
        end else if (advance_i) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstz_i) begin
            state_q <= seed_fix(seed_i);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bt_air_channel.sv
// bt_air_channel
// Cycle-accurate air interface joining N_DEV link controllers at 6 MHz.
// Each transmitter's {txen, txbit, txfk} passes through a DELAY_CYC-deep
// propagation delay; every receiver hears the single co-channel transmitter
// (other than itself), flags a collision when two or more are present, and
// otherwise sees LFSR noise. Received bits may be flipped for whole 1 us
// bit periods at a programmable rate, and flips seen on valid links are counted.
// Ports:
//   clk_6M, rstz             clock, synchronous active-low reset
//   p_1us                    1 MHz bit strobe (one cycle wide)
//   txen/txbit/txfk          per-device transmit enable, bit, channel
//   rxen/rxfk                per-device receive enable, channel
//   regi_err_en              enable bit-error injection
//   regi_ber_thresh          flip when LFSR < threshold
//   regi_seed                LFSR seed base (receiver r uses seed ^ r)
//   regi_seed_load_p         reload LFSRs, clear flips and error counters
//   rxbit/rxvalid/collision  registered per-receiver outputs
//   err_cnt                  per-receiver saturating flip counters
module bt_air_channel
    import bt_air_pkg::*;
#(
    parameter int unsigned N_DEV     = 2,
    parameter int unsigned FK_W      = 7,
    parameter int unsigned DELAY_CYC = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic                   p_1us,
    input  logic [N_DEV-1:0]       txen,
    input  logic [N_DEV-1:0]       txbit,
    input  logic [N_DEV*FK_W-1:0]  txfk,
    input  logic [N_DEV-1:0]       rxen,
    input  logic [N_DEV*FK_W-1:0]  rxfk,
    input  logic                   regi_err_en,
    input  logic [15:0]            regi_ber_thresh,
    input  logic [15:0]            regi_seed,
    input  logic                   regi_seed_load_p,
    output logic [N_DEV-1:0]       rxbit,
    output logic [N_DEV-1:0]       rxvalid,
    output logic [N_DEV-1:0]       collision,
    output logic [N_DEV*CNT_W-1:0] err_cnt
);

    tx_rec_t            tx_cur_s [N_DEV];
    tx_rec_t            dly_q    [DELAY_CYC][N_DEV];
    logic [TX_FK_W-1:0] rx_fk_s  [N_DEV];
    logic [LFSR_W-1:0]  lfsr_s   [N_DEV];
    logic [CNT_W-1:0]   cnt_q    [N_DEV];
    logic [CNT_W-1:0]   cnt_d    [N_DEV];

    logic [N_DEV-1:0] rxbit_q,   rxbit_d;
    logic [N_DEV-1:0] rxvalid_q, rxvalid_d;
    logic [N_DEV-1:0] coll_q,    coll_d;
    logic [N_DEV-1:0] flip_q,    flip_d;

    // Per-device LFSRs and counter output mapping.
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
        logic [LFSR_W-1:0] seed_s;
        assign seed_s = regi_seed ^ LFSR_W'(gi);

        bt_air_lfsr u_lfsr (
            .clk_i     (clk_6M),
            .rstz_i    (rstz),
            .advance_i (p_1us),
            .load_i    (regi_seed_load_p),
            .seed_i    (seed_s),
            .state_o   (lfsr_s[gi])
        );

        assign err_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end

    // Unpack the flat per-device buses into TX records and RX channels.
    always_comb begin
        for (int unsigned d = 0; d < N_DEV; d++) begin
            tx_cur_s[d].en  = txen[d];
            tx_cur_s[d].dat = txbit[d];
            tx_cur_s[d].fk  = TX_FK_W'(txfk[d*FK_W +: FK_W]);
            rx_fk_s[d]      = TX_FK_W'(rxfk[d*FK_W +: FK_W]);
        end
    end

    // Propagation delay line; stage DELAY_CYC-1 is what the receivers hear.
    always_ff @(posedge clk_6M) begin
        for (int unsigned d = 0; d < N_DEV; d++) begin
            if (!rstz) begin
                for (int unsigned s = 0; s < DELAY_CYC; s++) begin
                    dly_q[s][d] <= '0;
                end
            end else begin
                dly_q[0][d] <= tx_cur_s[d];
                for (int unsigned s = 1; s < DELAY_CYC; s++) begin
                    dly_q[s][d] <= dly_q[s-1][d];
                end
            end
        end
    end

    // Match counting per receiver, next outputs, flip latch and error counter.
    always_comb begin
        logic [3:0] n_v;
        logic       b_v;
        rxbit_d   = '0;
        rxvalid_d = '0;
        coll_d    = '0;
        flip_d    = flip_q;
        n_v       = 4'd0;
        b_v       = 1'b0;
        for (int unsigned r = 0; r < N_DEV; r++) begin
            cnt_d[r] = cnt_q[r];
            n_v      = 4'd0;
            b_v      = 1'b0;
            // A device never hears itself, and out-of-range channels are silent.
            for (int unsigned t = 0; t < N_DEV; t++) begin
                if ((t != r) && dly_q[DELAY_CYC-1][t].en &&
                    fk_in_range(dly_q[DELAY_CYC-1][t].fk) &&
                    (dly_q[DELAY_CYC-1][t].fk == rx_fk_s[r])) begin
                    n_v = n_v + 4'd1;
                    b_v = dly_q[DELAY_CYC-1][t].dat;
                end else begin
                    n_v = n_v;
                    b_v = b_v;
                end
            end

            if (!rxen[r]) begin
                rxbit_d[r]   = 1'b0;
                rxvalid_d[r] = 1'b0;
                coll_d[r]    = 1'b0;
            end else begin
                case (n_v)
                    4'd0: begin
                        rxbit_d[r]   = lfsr_s[r][0];
                        rxvalid_d[r] = 1'b0;
                        coll_d[r]    = 1'b0;
                    end
                    4'd1: begin
                        rxbit_d[r]   = b_v ^ flip_q[r];
                        rxvalid_d[r] = 1'b1;
                        coll_d[r]    = 1'b0;
                    end
                    default: begin
                        rxbit_d[r]   = lfsr_s[r][0];
                        rxvalid_d[r] = 1'b0;
                        coll_d[r]    = 1'b1;
                    end
                endcase
            end

            // flip is decided once per bit period from the pre-advance LFSR value.
            if (regi_seed_load_p) begin
                flip_d[r] = 1'b0;
            end else if (p_1us) begin
                flip_d[r] = regi_err_en && (lfsr_s[r] < regi_ber_thresh);
            end else begin
                flip_d[r] = flip_q[r];
            end

            // Count the bit period just ended if it was flipped on a valid link.
            if (regi_seed_load_p) begin
                cnt_d[r] = '0;
            end else if (p_1us && flip_q[r] && rxvalid_q[r] &&
                         (cnt_q[r] != {CNT_W{1'b1}})) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Registered outputs, flip latch and error counters.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            rxbit_q   <= '0;
            rxvalid_q <= '0;
            coll_q    <= '0;
            flip_q    <= '0;
            for (int unsigned r = 0; r < N_DEV; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rxbit_q   <= rxbit_d;
            rxvalid_q <= rxvalid_d;
            coll_q    <= coll_d;
            flip_q    <= flip_d;
            for (int unsigned r = 0; r < N_DEV; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign rxbit     = rxbit_q;
    assign rxvalid   = rxvalid_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_bt_air_channel.sv
// tb_bt_air_channel
// Directed bench for bt_air_channel with three devices. Two instances share
// all inputs: one with 16-bit error counters, one with 4-bit counters so
// saturation is reachable. A behavioural model (history of air samples,
// per-receiver LFSR/flip/count) predicts every output each cycle; literal
// expectations at key points pin the model itself.
module tb_bt_air_channel;

    localparam int N   = 3;
    localparam int D   = 3;
    localparam int FKW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstz, p_1us, err_en, load;
    logic [N-1:0]     txen, txbit, rxen;
    logic [N*FKW-1:0] txfk, rxfk;
    logic [15:0]      thresh, seed;
    logic [N-1:0]     rxbit, rxvalid, coll;
    logic [N-1:0]     rxbit4, rxvalid4, coll4;
    logic [N*16-1:0]  err_cnt;
    logic [N*4-1:0]   err_cnt4;

    bt_air_channel #(.N_DEV(N), .FK_W(FKW), .DELAY_CYC(D), .CNT_W(16)) u_dut (
        .clk_6M(clk), .rstz(rstz), .p_1us(p_1us),
        .txen(txen), .txbit(txbit), .txfk(txfk), .rxen(rxen), .rxfk(rxfk),
        .regi_err_en(err_en), .regi_ber_thresh(thresh), .regi_seed(seed),
        .regi_seed_load_p(load),
        .rxbit(rxbit), .rxvalid(rxvalid), .collision(coll), .err_cnt(err_cnt)
    );

    bt_air_channel #(.N_DEV(N), .FK_W(FKW), .DELAY_CYC(D), .CNT_W(4)) u_dut4 (
        .clk_6M(clk), .rstz(rstz), .p_1us(p_1us),
        .txen(txen), .txbit(txbit), .txfk(txfk), .rxen(rxen), .rxfk(rxfk),
        .regi_err_en(err_en), .regi_ber_thresh(thresh), .regi_seed(seed),
        .regi_seed_load_p(load),
        .rxbit(rxbit4), .rxvalid(rxvalid4), .collision(coll4), .err_cnt(err_cnt4)
    );

    int n_vec = 0;
    int n_bad = 0;
    int phase = 0;

    // Model state: air history (index 0 newest), LFSR, flip, true flip count.
    logic        h_en  [D][N];
    logic        h_bit [D][N];
    int          h_fk  [D][N];
    logic [15:0] m_lfsr [N];
    logic        m_flip [N];
    int          m_cnt  [N];
    logic [N-1:0] exp_rxbit, exp_rxvalid, exp_coll;
    logic [N*16-1:0] e16;
    logic [N*4-1:0]  e4;

    logic [7:0] data, got;
    int n0;

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] w);
        n_vec++;
        if (g !== w) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, g, w, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [15:0] seed_of(input int r);
        logic [15:0] s;
        s = seed ^ 16'(r);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic int fk_of(input logic [N*FKW-1:0] v, input int d);
        logic [FKW-1:0] f;
        f = v[d*FKW +: FKW];
        return int'(f);
    endfunction

    // Predict the outputs right after the coming posedge from the current inputs.
    task automatic model_step();
        int nm;
        logic hb;
        logic [N-1:0] nb, nv, nc;
        if (!rstz) begin
            for (int si = 0; si < D; si++) begin
                for (int d = 0; d < N; d++) begin
                    h_en[si][d] = 1'b0; h_bit[si][d] = 1'b0; h_fk[si][d] = 0;
                end
            end
            for (int r = 0; r < N; r++) begin
                m_cnt[r] = 0; m_flip[r] = 1'b0; m_lfsr[r] = seed_of(r);
            end
            exp_rxbit = '0; exp_rxvalid = '0; exp_coll = '0;
        end else begin
            nb = '0; nv = '0; nc = '0;
            for (int r = 0; r < N; r++) begin
                nm = 0; hb = 1'b0;
                for (int t = 0; t < N; t++) begin
                    if (t != r && h_en[D-1][t] && h_fk[D-1][t] <= 78 &&
                        h_fk[D-1][t] == fk_of(rxfk, r)) begin
                        nm++; hb = h_bit[D-1][t];
                    end
                end
                if (rxen[r]) begin
                    if (nm == 0) nb[r] = m_lfsr[r][0];
                    else if (nm == 1) begin nb[r] = hb ^ m_flip[r]; nv[r] = 1'b1; end
                    else begin nb[r] = m_lfsr[r][0]; nc[r] = 1'b1; end
                end
            end
            for (int r = 0; r < N; r++) begin
                if (load) begin
                    m_cnt[r] = 0; m_flip[r] = 1'b0; m_lfsr[r] = seed_of(r);
                end else if (p_1us) begin
                    if (m_flip[r] && exp_rxvalid[r]) m_cnt[r]++;
                    m_flip[r] = err_en && (m_lfsr[r] < thresh);
                    m_lfsr[r] = lfsr_next(m_lfsr[r]);
                end
            end
            exp_rxbit = nb; exp_rxvalid = nv; exp_coll = nc;
            for (int si = D-1; si > 0; si--) begin
                for (int d = 0; d < N; d++) begin
                    h_en[si][d] = h_en[si-1][d]; h_bit[si][d] = h_bit[si-1][d];
                    h_fk[si][d] = h_fk[si-1][d];
                end
            end
            for (int d = 0; d < N; d++) begin
                h_en[0][d] = txen[d]; h_bit[0][d] = txbit[d]; h_fk[0][d] = fk_of(txfk, d);
            end
        end
    endtask

    // One clock cycle: strobe, model prediction, then step to the next negedge.
    task automatic cyc();
        p_1us = (phase == 0);
        phase = (phase == 5) ? 0 : phase + 1;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic align();
        while (phase != 0) cyc();
    endtask

    task automatic set_tx(input int d, input logic en, input int fk);
        txen[d] = en;
        txfk[d*FKW +: FKW] = 7'(fk);
    endtask

    task automatic set_rx(input int d, input logic en, input int fk);
        rxen[d] = en;
        rxfk[d*FKW +: FKW] = 7'(fk);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #2;
        for (int r = 0; r < N; r++) begin
            e16[r*16 +: 16] = (m_cnt[r] > 65535) ? 16'hFFFF : 16'(m_cnt[r]);
            e4[r*4 +: 4]    = (m_cnt[r] > 15) ? 4'hF : 4'(m_cnt[r]);
        end
        chk("rxbit",      64'(rxbit),    64'(exp_rxbit));
        chk("rxvalid",    64'(rxvalid),  64'(exp_rxvalid));
        chk("collision",  64'(coll),     64'(exp_coll));
        chk("err_cnt",    64'(err_cnt),  64'(e16));
        chk("rxbit4",     64'(rxbit4),   64'(exp_rxbit));
        chk("rxvalid4",   64'(rxvalid4), 64'(exp_rxvalid));
        chk("collision4", 64'(coll4),    64'(exp_coll));
        chk("err_cnt4",   64'(err_cnt4), 64'(e4));
    end

    initial begin
        // LFSR of receiver 1 starts one step past 16'hFFFF, so a 100% threshold
        // flips every bit for the next 65534 steps.
        rstz = 1'b0; p_1us = 1'b0; err_en = 1'b0; load = 1'b0;
        thresh = 16'h0000; seed = 16'hCBFE;
        txen = '0; txbit = '0; rxen = '0; txfk = '0; rxfk = '0;
        repeat (3) cyc();
        chk("reset_rxbit",   64'(rxbit),   64'd0);
        chk("reset_rxvalid", 64'(rxvalid), 64'd0);
        chk("reset_coll",    64'(coll),    64'd0);
        chk("reset_errcnt",  64'(err_cnt), 64'd0);
        rstz = 1'b1;

        // Point-to-point: dev0 -> dev1 on fk 5, 0xA5 MSB-first.
        set_tx(0, 1'b1, 5); set_rx(1, 1'b1, 5);
        align();
        data = 8'hA5; got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 6; j++) begin
                txbit[0] = data[7-i];
                cyc();
                if (j == 5) begin
                    got = {got[6:0], rxbit[1]};
                    chk("p2p_valid", 64'(rxvalid[1]), 64'd1);
                end
            end
        end
        chk("p2p_data",   64'(got),           64'hA5);
        chk("p2p_errcnt", 64'(err_cnt[31:16]), 64'd0);

        // Collision: dev0 and dev1 on fk 20, dev2 listening on fk 20.
        set_rx(1, 1'b0, 0);
        set_tx(0, 1'b1, 20); set_tx(1, 1'b1, 20); set_rx(2, 1'b1, 20);
        txbit = 3'b001;
        repeat (6) cyc();
        chk("coll_on",    64'(coll[2]),    64'd1);
        chk("coll_noval", 64'(rxvalid[2]), 64'd0);
        set_tx(1, 1'b1, 21);
        repeat (3) cyc();
        chk("coll_hold", 64'(coll[2]), 64'd1);
        cyc();
        chk("coll_off",   64'(coll[2]),    64'd0);
        chk("coll_valid", 64'(rxvalid[2]), 64'd1);
        chk("coll_bit",   64'(rxbit[2]),   64'd1);

        // Channel range: 78 is usable, 79 is not; mismatched RX is invalid.
        txen = '0; rxen = '0;
        set_tx(0, 1'b1, 78); set_rx(1, 1'b1, 78);
        repeat (6) cyc();
        chk("fk78_valid", 64'(rxvalid[1]), 64'd1);
        set_tx(0, 1'b1, 79); set_rx(1, 1'b1, 79);
        repeat (6) cyc();
        chk("fk79_valid", 64'(rxvalid[1]), 64'd0);
        chk("fk79_coll",  64'(coll[1]),    64'd0);
        set_tx(0, 1'b1, 5); set_rx(1, 1'b1, 6);
        repeat (6) cyc();
        chk("fk_mismatch", 64'(rxvalid[1]), 64'd0);

        // Full error rate on a constant-1 link for 1000 bits.
        set_rx(1, 1'b1, 5); txbit = 3'b001;
        err_en = 1'b1; thresh = 16'hFFFF;
        repeat (6) cyc();
        align();
        load = 1'b1; cyc(); load = 1'b0;
        n0 = 0;
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < 6; j++) begin
                cyc();
                if (j == 5 && rxbit[1] == 1'b0) n0++;
            end
        end
        chk("ber_full_zeros", 64'(n0),              64'd999);
        chk("ber_full_cnt",   64'(err_cnt[31:16]),  64'd999);
        chk("cnt4_saturated", 64'(err_cnt4[7:4]),   64'd15);

        // Seed reload coincident with the strobe clears the counters.
        align();
        load = 1'b1; cyc(); load = 1'b0;
        chk("load_clr16", 64'(err_cnt),  64'd0);
        chk("load_clr4",  64'(err_cnt4), 64'd0);

        // Zero threshold: no flips at all.
        thresh = 16'h0000;
        repeat (600) cyc();
        chk("ber_zero_cnt", 64'(err_cnt[31:16]), 64'd0);

        // Reset in the middle of a flipped transmission.
        thresh = 16'hFFFF;
        repeat (63) cyc();
        rstz = 1'b0; cyc(); rstz = 1'b1;
        chk("mid_rst_rxbit",   64'(rxbit),    64'd0);
        chk("mid_rst_rxvalid", 64'(rxvalid),  64'd0);
        chk("mid_rst_coll",    64'(coll),     64'd0);
        chk("mid_rst_errcnt",  64'(err_cnt),  64'd0);
        chk("mid_rst_errcnt4", 64'(err_cnt4), 64'd0);
        txen = '0; err_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_rst_novalid", 64'(rxvalid[1]), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
